// File: rtl/seg_scan_if.sv
// Bus between the digit counter / seg7 decoder and seg_scan_mux: load side plus scanned outputs.
interface seg_scan_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_mask;
  logic [3:0]            digit;
  logic [DIGITS-1:0]     digit_sel;
  logic                  dp;
  logic                  blank;
  logic                  frame_done;

  modport master (
    output load, value, dp_mask,
    input  digit, digit_sel, dp, blank, frame_done
  );

  modport slave (
    input  load, value, dp_mask,
    output digit, digit_sel, dp, blank, frame_done
  );
endinterface

// File: rtl/seg_scan_mux.sv
// Multiplexed display scanner: shadow/display registers, per-slot DEAD/ON scan, frame-boundary updates.
// Optional leading-zero blanking is compiled in when SEG_SCAN_LZB_EN is defined.
module seg_scan_mux #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 10000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  seg_scan_if.slave  bus
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] LAST_CNT = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] DEAD_CNT = CW'(DEAD_CYCLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  typedef enum logic {
    ST_DEAD,
    ST_ON
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        slotCnt_q, slotCnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [4*DIGITS-1:0]  shadowVal_q, shadowVal_d;
  logic [DIGITS-1:0]    shadowDp_q, shadowDp_d;
  logic                 pending_q, pending_d;
  logic [4*DIGITS-1:0]  dispVal_q, dispVal_d;
  logic [DIGITS-1:0]    dispDp_q, dispDp_d;

  logic [3:0]           digit_q, digit_d;
  logic [DIGITS-1:0]    digitSel_q, digitSel_d;
  logic                 dp_q, dp_d;
  logic                 blank_q, blank_d;
  logic                 frameDone_q, frameDone_d;

  logic                 slotEnd;
  logic                 frameEnd;
  logic [DIGITS-1:0]    lzbMask;
  logic [3:0]           nibSel;
  logic                 dpSel;
  logic                 lzbSel;
  logic                 showDigit;

  // Scan position, shadow capture and the frame-boundary display swap.
  // A load on the boundary cycle sets pending and is consumed in the same
  // cycle, which gives the bypass straight into the display register.
  always_comb begin
    slotEnd     = (slotCnt_q == LAST_CNT);
    frameEnd    = slotEnd && (idx_q == LAST_IDX);
    slotCnt_d   = slotEnd ? '0 : slotCnt_q + CW'(1);
    idx_d       = idx_q;
    if (slotEnd) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
    end

    shadowVal_d = shadowVal_q;
    shadowDp_d  = shadowDp_q;
    pending_d   = pending_q;
    dispVal_d   = dispVal_q;
    dispDp_d    = dispDp_q;
    if (bus.load) begin
      shadowVal_d = bus.value;
      shadowDp_d  = bus.dp_mask;
      pending_d   = 1'b1;
    end
    if (frameEnd && pending_d) begin
      dispVal_d = shadowVal_d;
      dispDp_d  = shadowDp_d;
      pending_d = 1'b0;
    end

    state_d = state_q;
    case (state_q)
      ST_DEAD: state_d = (slotCnt_d >= DEAD_CNT) ? ST_ON : ST_DEAD;
      ST_ON:   state_d = slotEnd ? ST_DEAD : ST_ON;
      default: state_d = ST_DEAD;
    endcase
  end

`ifdef SEG_SCAN_LZB_EN
  logic allZero;

  // The display register only changes at frame boundaries, so deriving the
  // mask from the next display contents matches a per-boundary computation.
  always_comb begin
    lzbMask = '0;
    allZero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      allZero    = allZero && (dispVal_d[4*k +: 4] == 4'h0);
      lzbMask[k] = allZero && !dispDp_d[k];
    end
  end
`else
  assign lzbMask = '0;
`endif

  // Next values of the registered outputs, taken from the next scan position
  // so outputs line up with the slot counter and state after the edge.
  always_comb begin
    nibSel = 4'h0;
    dpSel  = 1'b0;
    lzbSel = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_d == IW'(k)) begin
        nibSel = dispVal_d[4*k +: 4];
        dpSel  = dispDp_d[k];
        lzbSel = lzbMask[k];
      end
    end
    showDigit   = (state_d == ST_ON) && !lzbSel;
    digit_d     = nibSel;
    digitSel_d  = showDigit ? (DIGITS'(1) << idx_d) : '0;
    dp_d        = showDigit && dpSel;
    blank_d     = !showDigit;
    frameDone_d = (slotCnt_d == LAST_CNT) && (idx_d == LAST_IDX);
  end

  // FSM, datapath and output registers share one reset domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_DEAD;
      slotCnt_q   <= '0;
      idx_q       <= '0;
      shadowVal_q <= '0;
      shadowDp_q  <= '0;
      pending_q   <= 1'b0;
      dispVal_q   <= '0;
      dispDp_q    <= '0;
      digit_q     <= 4'h0;
      digitSel_q  <= '0;
      dp_q        <= 1'b0;
      blank_q     <= 1'b1;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      slotCnt_q   <= slotCnt_d;
      idx_q       <= idx_d;
      shadowVal_q <= shadowVal_d;
      shadowDp_q  <= shadowDp_d;
      pending_q   <= pending_d;
      dispVal_q   <= dispVal_d;
      dispDp_q    <= dispDp_d;
      digit_q     <= digit_d;
      digitSel_q  <= digitSel_d;
      dp_q        <= dp_d;
      blank_q     <= blank_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign bus.digit      = digit_q;
  assign bus.digit_sel  = digitSel_q;
  assign bus.dp         = dp_q;
  assign bus.blank      = blank_q;
  assign bus.frame_done = frameDone_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux (DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2) against a
// time-indexed reference model; follows SEG_SCAN_LZB_EN when it is defined.
module tb_seg_scan_mux;

  localparam int DIGITS = 4;
  localparam int RD     = 8;
  localparam int DC     = 2;
  localparam int FRAME  = DIGITS * RD;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  seg_scan_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_mux #(
    .DIGITS(DIGITS),
    .REFRESH_DIV(RD),
    .DEAD_CYCLES(DC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: cycles since reset release plus what the display should hold.
  int          t;
  logic [15:0] mShadow, mDisp;
  logic [3:0]  mShadowDp, mDispDp;
  bit          mPending;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  function automatic bit lzbHidden(input int slot);
`ifdef SEG_SCAN_LZB_EN
    if (slot == 0) return 1'b0;
    return ((mDisp >> (4 * slot)) == 16'h0) && !mDispDp[slot];
`else
    return (slot < 0);
`endif
  endfunction

  task automatic checkAll();
    int pos, slot, w;
    bit on, lit;
    logic [3:0] expSel;
    pos    = t % FRAME;
    slot   = pos / RD;
    w      = pos % RD;
    on     = (w >= DC);
    lit    = on && !lzbHidden(slot);
    expSel = lit ? 4'(1 << slot) : 4'b0;
    checkOutput("digit_sel", 16'(bus.digit_sel), 16'(expSel));
    checkOutput("blank", 16'(bus.blank), 16'(!lit));
    checkOutput("dp", 16'(bus.dp), 16'(lit && mDispDp[slot]));
    checkOutput("frame_done", 16'(bus.frame_done), 16'(pos == FRAME - 1));
    if (lit) checkOutput("digit", 16'(bus.digit), 16'((mDisp >> (4 * slot)) & 16'hF));
  endtask

  task automatic modelReset();
    mShadow   = '0;
    mShadowDp = '0;
    mDisp     = '0;
    mDispDp   = '0;
    mPending  = 1'b0;
    t         = 0;
  endtask

  // One cycle: check at the negedge, drive, then advance the model at the posedge.
  task automatic applyStimulus(input bit ld, input logic [15:0] v, input logic [3:0] m);
    checkAll();
    bus.load    = ld;
    bus.value   = v;
    bus.dp_mask = m;
    @(posedge clk);
    if (ld) begin
      mShadow   = v;
      mShadowDp = m;
      mPending  = 1'b1;
    end
    if ((t % FRAME == FRAME - 1) && mPending) begin
      mDisp    = mShadow;
      mDispDp  = mShadowDp;
      mPending = 1'b0;
    end
    t++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'($urandom), 4'($urandom));
  endtask

  task automatic runToPos(input int p);
    for (int i = 0; i < FRAME && (t % FRAME) != p; i++) idle(1);
  endtask

  initial begin
    bus.load    = 1'b0;
    bus.value   = '0;
    bus.dp_mask = '0;
    modelReset();

    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_digit_sel", 16'(bus.digit_sel), 16'h0);
      checkOutput("rst_blank", 16'(bus.blank), 16'h1);
      checkOutput("rst_dp", 16'(bus.dp), 16'h0);
      checkOutput("rst_digit", 16'(bus.digit), 16'h0);
      checkOutput("rst_frame_done", 16'(bus.frame_done), 16'h0);
    end
    rst_n = 1'b1;
    idle(FRAME + 3);

    runToPos(10);
    applyStimulus(1'b1, 16'h1234, 4'b0100);
    runToPos(0);
    idle(FRAME);

    runToPos(5);
    applyStimulus(1'b1, 16'hAAAA, 4'($urandom));
    runToPos(20);
    applyStimulus(1'b1, 16'h0BCD, 4'b0000);
    runToPos(0);
    idle(FRAME);

    runToPos(FRAME - 1);
    applyStimulus(1'b1, 16'h5678, 4'b0000);
    idle(FRAME);

    runToPos(FRAME - 1);
    applyStimulus(1'b1, 16'h0050, 4'b0000);
    idle(FRAME);
    runToPos(FRAME - 1);
    applyStimulus(1'b1, 16'h0000, 4'b0000);
    idle(FRAME);

    for (int i = 0; i < 6 * FRAME; i++)
      applyStimulus(($urandom % 8) == 0, 16'($urandom), 4'($urandom));
    idle(FRAME);

    runToPos(FRAME - 1);
    applyStimulus(1'b1, 16'h9ABC, 4'b1111);
    runToPos(10);
    applyStimulus(1'b1, 16'h4321, 4'b0001);
    runToPos(20);
    checkAll();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_digit_sel", 16'(bus.digit_sel), 16'h0);
    checkOutput("async_rst_blank", 16'(bus.blank), 16'h1);
    checkOutput("async_rst_dp", 16'(bus.dp), 16'h0);
    modelReset();
    @(negedge clk);
    checkOutput("hold_rst_digit_sel", 16'(bus.digit_sel), 16'h0);
    checkOutput("hold_rst_blank", 16'(bus.blank), 16'h1);
    rst_n = 1'b1;
    idle(2 * FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Multiplexed display scanner that sits directly downstream of the digit counter and upstream of the `seg7` decoder. It captures a packed multi-digit value and time-multiplexes it onto one shared nibble bus. For each digit slot it drives a one-hot digit enable, with a dead interval between slots to suppress ghosting. New values are applied only at frame boundaries, so a refresh never shows a mix of old and new digits.

## Interface
Parameters:
- `DIGITS`, 4: number of digits scanned; legal range 2–8.
- `REFRESH_DIV`, 10000: clock cycles per digit slot; must be greater than `DEAD_CYCLES`.
- `DEAD_CYCLES`, 16: cycles at the start of each slot with all digits off; legal range ≥1.

Ports:
- `clk` in 1: single clock; every flop is clocked on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low. All flops use it.
- `load` in 1: one-cycle strobe that captures `value` and `dp_mask`.
- `value` in 4*DIGITS: packed digits; `[3:0]` is digit 0 (least significant).
- `dp_mask` in DIGITS: decimal-point request for each digit.
- `digit` out 4: nibble for the shared `seg7` decoder.
- `digit_sel` out DIGITS: one-hot digit enable, active-high.
- `dp` out 1: decimal point for the currently enabled digit.
- `blank` out 1: while high, the decoder outputs must be forced off.
- `frame_done` out 1: one-cycle pulse at the end of each full scan.

## Operation
- Registers:
  - Shadow register: `value` and `dp_mask` sampled when `load` is high; also sets `pending`.
  - Display register: drives the scan.
  - Slot counter: `$clog2(REFRESH_DIV)` bits, runs 0..REFRESH_DIV-1.
  - Digit index `idx`: runs 0..DIGITS-1, then wraps to 0.
- Two-state FSM, evaluated per slot:
  - DEAD while the slot counter < DEAD_CYCLES. In DEAD: `digit_sel`=0, `blank`=1, `dp`=0.
  - ON for the rest of the slot. In ON: `digit_sel[idx]`=1, `digit` is display nibble `idx`, `dp` is display `dp_mask[idx]`, `blank`=0.
  - When the slot counter reaches REFRESH_DIV-1: counter returns to 0, `idx` increments, FSM goes to DEAD.
- Frame boundary is the last cycle of slot DIGITS-1. On that cycle:
  - `frame_done`=1.
  - If `pending`, the display register takes the shadow contents and `pending` clears.
- `load` on the boundary cycle: the shadow captures the new value and it goes straight to the display register (bypass). `pending` ends cleared.
- Several `load`s within one frame: last one wins.
- Nibbles 10–15 pass through unmodified; the decoder renders them as hex.
- Reset values, asserted immediately on `rst_n` low (including mid-frame):
  - `digit_sel`=0, `digit`=0, `dp`=0, `blank`=1, `frame_done`=0.
  - `idx`=0, slot counter=0, state DEAD.
  - Shadow=0, display=0, `pending`=0.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- After `rst_n` is released:
  - DEAD for DEAD_CYCLES cycles.
  - Then `digit_sel[0]` high for REFRESH_DIV-DEAD_CYCLES cycles.
- Frame period is exactly DIGITS*REFRESH_DIV cycles. `frame_done` pulses once per period.
- Load-to-display latency:
  - At least 1 cycle (load on the boundary cycle).
  - At most DIGITS*REFRESH_DIV cycles.
  - New data is first visible on slot 0 of the next frame.
- `digit_sel` is never multi-hot, including across slot transitions and reset.

## Configuration
- `SEG_SCAN_LZB_EN` defined: leading-zero blanking is compiled in.
  - At each frame-boundary update, the block computes a blank mask for the new display contents.
  - Digits from DIGITS-1 down to 1 are blanked while they and every higher digit are 0 and their dp bit is 0.
  - In the ON phase of a blanked slot: `digit_sel`=0 and `blank`=1.
  - Digit 0 is never blanked.
- `SEG_SCAN_LZB_EN` undefined: no blanking logic is present; every digit is always shown.

## Test plan
All scenarios use DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2.
- Reset, then release → `blank`=1 and `digit_sel`=0 for 2 cycles; then `digit_sel`=4'b0001 for 6 cycles; `frame_done` pulses at cycle 31.
- `load` with value=16'h1234, dp_mask=4'b0100, mid-frame → old data continues until the boundary. Next frame shows `digit` 4,3,2,1 on `digit_sel` 1,2,4,8, with `dp`=1 only on slot 2.
- Two `load`s in one frame (16'hAAAA then 16'h0BCD) → next frame shows D,C,B,0. 16'hAAAA is never displayed.
- `load` 16'h5678 exactly on the `frame_done` cycle → the next cycle's frame shows 8,7,6,5.
- `rst_n` pulsed low during the ON phase of slot 2 → `digit_sel` goes to 0 and `blank` to 1 immediately. After release the scan restarts at slot 0 with display=0.
- With `SEG_SCAN_LZB_EN`, `load` 16'h0050 → slots 3 and 2 are dark with `blank`=1; slots 1 and 0 show 5 and 0. `load` 16'h0000 → only slot 0 lights, showing 0.
